// File: rtl/risc_pkg.sv
// Shared definitions for the fetch datapath and its controller: opcode
// constants, default datapath widths and the fetch FSM state encoding.
package risc_pkg;

  // Default datapath widths; an instruction is a 3-bit opcode plus an
  // AWIDTH-bit operand, so DWIDTH must equal 3 + AWIDTH.
  localparam int AWIDTH = 5;
  localparam int DWIDTH = 8;

  // Instruction opcodes decoded by the controller.
  typedef enum logic [2:0] {
    HLT = 3'b000,
    SKZ = 3'b001,
    ADD = 3'b010,
    AND = 3'b011,
    XOR = 3'b100,
    LDA = 3'b101,
    STO = 3'b110,
    JMP = 3'b111
  } opcode_e;

  // Fetch stage run/halt state; HALTED is left only through reset.
  typedef enum logic {
    FETCH_RUN    = 1'b0,
    FETCH_HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pc_counter.sv
// Loadable, wrapping program counter. Load has priority over increment and
// both are gated by the enable, which the fetch FSM drives while running.
module pc_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         ld,
  input  logic         inc,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Next PC: load beats increment, increment wraps at 2^W, else hold.
  always_comb begin
    // NOTE: assigning the hold value first means every path writes q_d, so no latch is inferred.
    q_d = q_q;
    if (en) begin
      if (ld) begin
        q_d = d;
      end else if (inc) begin
        q_d = q_q + W'(1);
      end
    end
  end

  // PC register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignment keeps every register sampling pre-edge values, independent of block order.
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC (via pc_counter), instruction register, memory
// address mux, run/halt FSM and a saturating retired-instruction counter.
module fetch_unit #(
  parameter int AWIDTH = risc_pkg::AWIDTH,
  parameter int DWIDTH = risc_pkg::DWIDTH,
  parameter int CWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              ld_ir,
  input  logic              inc_pc,
  input  logic              ld_pc,
  input  logic              halt,
  input  logic [DWIDTH-1:0] data_in,
  output logic [2:0]        opcode,
  output logic [AWIDTH-1:0] operand,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [AWIDTH-1:0] pc,
  output logic              halted,
  output logic [CWIDTH-1:0] instr_count
);

  import risc_pkg::*;

  fetch_state_e      state_q;
  fetch_state_e      state_d;
  logic              run_en;
  logic [DWIDTH-1:0] ir_q;
  logic [DWIDTH-1:0] ir_d;
  logic [CWIDTH-1:0] cnt_q;
  logic [CWIDTH-1:0] cnt_d;

  // FSM state register; reset always returns to RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a sampled halt parks the stage until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_RUN:    if (halt) state_d = FETCH_HALTED;
      FETCH_HALTED: state_d = FETCH_HALTED;
      default:      state_d = FETCH_RUN;
    endcase
  end

  // FSM outputs: enable for all datapath updates and the sticky status.
  always_comb begin
    run_en = 1'b0;
    halted = 1'b0;
    case (state_q)
      FETCH_RUN:    run_en = 1'b1;
      FETCH_HALTED: halted = 1'b1;
      default:      run_en = 1'b0;
    endcase
  end

  // The PC loads from the current IR operand, so a same-edge IR load does
  // not affect the jump target.
  pc_counter #(
    .W (AWIDTH)
  ) u_pc_counter (
    .clk (clk),
    .rst (rst),
    .en  (run_en),
    .ld  (ld_pc),
    .inc (inc_pc),
    .d   (operand),
    .q   (pc)
  );

  // IR and instruction counter next state; counter saturates at all-ones.
  always_comb begin
    ir_d  = ir_q;
    cnt_d = cnt_q;
    if (run_en && ld_ir) begin
      ir_d = data_in;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CWIDTH'(1);
      end
    end
  end

  // IR and instruction counter registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q  <= '0;
      cnt_q <= '0;
    end else begin
      ir_q  <= ir_d;
      cnt_q <= cnt_d;
    end
  end

  assign opcode      = ir_q[DWIDTH-1 -: 3];
  assign operand     = ir_q[AWIDTH-1:0];
  assign mem_addr    = sel ? pc : operand;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// strobes compared against a behavioural model of the fetch stage.
module tb_fetch_unit;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int PC_MOD = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          sel, ld_ir, inc_pc, ld_pc, halt;
  logic [DW-1:0] data_in;
  logic [2:0]    opcode;
  logic [AW-1:0] operand, mem_addr, pc;
  logic          halted;
  logic [CW-1:0] instr_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_pc, m_ir, m_cnt;
  bit m_halted;

  fetch_unit #(.AWIDTH(AW), .DWIDTH(DW), .CWIDTH(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .sel         (sel),
    .ld_ir       (ld_ir),
    .inc_pc      (inc_pc),
    .ld_pc       (ld_pc),
    .halt        (halt),
    .data_in     (data_in),
    .opcode      (opcode),
    .operand     (operand),
    .mem_addr    (mem_addr),
    .pc          (pc),
    .halted      (halted),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_ir = 0; m_cnt = 0; m_halted = 0;
  endtask

  // Model of one rising edge, using the strobes currently driven.
  task automatic model_edge();
    int old_operand;
    if (m_halted) return;
    old_operand = m_ir % PC_MOD;
    if (ld_pc) m_pc = old_operand;
    else if (inc_pc) m_pc = (m_pc + 1) % PC_MOD;
    if (ld_ir) begin
      m_ir = int'(data_in);
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end
    if (halt) m_halted = 1;
  endtask

  task automatic check_all(input string tag);
    int exp_addr;
    exp_addr = sel ? m_pc : (m_ir % PC_MOD);
    chk({tag, ".pc"},       int'(pc),          m_pc);
    chk({tag, ".opcode"},   int'(opcode),      m_ir / PC_MOD);
    chk({tag, ".operand"},  int'(operand),     m_ir % PC_MOD);
    chk({tag, ".mem_addr"}, int'(mem_addr),    exp_addr);
    chk({tag, ".halted"},   int'(halted),      int'(m_halted));
    chk({tag, ".count"},    int'(instr_count), m_cnt);
  endtask

  // Drive strobes for one edge, update the model, then check after the edge.
  task automatic tick(input string tag, input logic s, input logic li, input logic ip,
                      input logic lp, input logic h, input logic [DW-1:0] d);
    sel = s; ld_ir = li; inc_pc = ip; ld_pc = lp; halt = h; data_in = d;
    @(posedge clk);
    model_edge();
    #1;
    ld_ir = 0; inc_pc = 0; ld_pc = 0; halt = 0;
    check_all(tag);
  endtask

  task automatic rand_ticks(input string tag, input int n, input int halt_odds);
    for (int i = 0; i < n; i++) begin
      tick(tag, 1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(3) == 0),
           (halt_odds != 0) && ($urandom_range(halt_odds - 1) == 0), 8'($urandom));
    end
  endtask

  initial begin
    rst = 1; sel = 1; ld_ir = 0; inc_pc = 0; ld_pc = 0; halt = 0; data_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    check_all("reset");
    rst = 0;
    @(posedge clk); #1;

    // Three increments with PC selected
    for (int i = 0; i < 3; i++) tick("inc3", 1, 0, 1, 0, 0, 8'h00);
    chk("inc3.pc_is_3", int'(pc), 3);

    // IR load, operand select, then ld_pc beating inc_pc
    tick("ldir", 1, 1, 0, 0, 0, 8'b111_01010);
    chk("ldir.opcode7", int'(opcode), 7);
    sel = 0; #1;
    chk("sel0.mem_addr10", int'(mem_addr), 10);
    tick("ldpc_inc", 0, 0, 1, 1, 0, 8'h00);
    chk("ldpc_inc.pc10", int'(pc), 10);

    // Wrap from 31 to 0
    tick("ir31", 1, 1, 0, 0, 0, 8'h1F);
    tick("pc31", 1, 0, 0, 1, 0, 8'h00);
    tick("wrap", 1, 0, 1, 0, 0, 8'h00);
    chk("wrap.pc0", int'(pc), 0);

    // Same-edge ld_ir and ld_pc: jump uses old operand 7
    tick("ir07", 1, 1, 0, 0, 0, 8'h07);
    tick("ir_a5_pc7", 1, 1, 0, 1, 0, 8'hA5);
    chk("same_edge.pc7", int'(pc), 7);

    // Counter saturation (small CWIDTH)
    for (int i = 0; i < CNT_MAX + 4; i++) tick("sat", 1, 1, 0, 0, 0, 8'($urandom));
    chk("sat.count_max", int'(instr_count), CNT_MAX);

    // Randomized running traffic, no halt
    rand_ticks("rand_run", 150, 0);

    // Park PC at 12, then halt alone
    tick("ir12", 1, 1, 0, 0, 0, 8'h0C);
    tick("pc12", 1, 0, 0, 1, 0, 8'h00);
    tick("halt", 1, 0, 0, 0, 1, 8'h00);
    chk("halt.halted", int'(halted), 1);
    for (int i = 0; i < 5; i++) tick("frozen", i[0], 1, 1, 1, 0, 8'($urandom));
    chk("frozen.pc12", int'(pc), 12);

    // Asynchronous reset mid-cycle
    #3;
    rst = 1;
    #1;
    model_reset();
    sel = 1; #0.1;
    check_all("async_rst_sel1");
    sel = 0; #0.1;
    check_all("async_rst_sel0");
    @(posedge clk); #2;
    rst = 0;
    sel = 1; #1;
    chk("post_rst.fetch_addr0", int'(mem_addr), 0);

    // Randomized traffic with occasional halts sharing edges with strobes
    rand_ticks("rand_halt", 60, 24);
    #3; rst = 1; #1; model_reset(); check_all("rst2");
    @(posedge clk); #2; rst = 0;
    tick("post_halt_strobe", 1, 1, 1, 1, 1, 8'h3C);
    chk("halt_edge.count1", int'(instr_count), 1);
    rand_ticks("rand_halt2", 40, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
